axil_shadow_bridge: RTL and testbench
=====================================

# axil_shadow_bridge

Parametrised AXI-Lite shadow register bridge between the CPU-side interconnect and the SD controller's AXI-Lite slave. Holds an N-entry shadow copy of the controller's 32-bit registers so sub-word CPU writes are merged locally, and only writes touching a per-register trigger byte lane are forwarded downstream as full 32-bit, all-strobe writes. Successor to the fixed byte-0-trigger shadow block: adds per-register trigger masks, an optional shadow-served read path, out-of-range SLVERR and a proper write FSM with downstream response propagation.

## Interface
- N, 8: number of shadowed 32-bit registers; register index = AWADDR[$clog2(N)+1:2], the upper address bits must be zero.
- TRIGGER_MASK, {N{4'b0001}}: 4 bits per register, where register i uses bits [4i+3:4i]; a write whose WSTRB overlaps this mask is forwarded.
- READ_SHADOW, 0: 0 means reads pass straight through to M_AXI; 1 means reads are served from the shadow.
- i_clk in 1: the single clock.
- i_reset_n in 1: asynchronous, active-low reset.
- S_AXIL_AW*: AWVALID in 1, AWREADY out 1, AWADDR in 32.
- S_AXIL_W*: WVALID in 1, WREADY out 1, WDATA in 32, WSTRB in 4.
- S_AXIL_B*: BVALID out 1, BREADY in 1, BRESP out 2.
- S_AXIL_AR*: ARVALID in 1, ARREADY out 1, ARADDR in 32.
- S_AXIL_R*: RVALID out 1, RREADY in 1, RDATA out 32, RRESP out 2.
- M_AXI_AW*, W*, B*, AR*, R*: mirror of the S_AXIL channels with directions reversed and identical widths.

## Operation
- Write FSM states: IDLE, MERGE, FWD, WAIT_B, RESP. One write is outstanding at a time.
- IDLE:
  - AWREADY is high while AW is not yet captured; WREADY is high while W is not yet captured. AW and W are captured independently, in either order or in the same cycle.
  - Go to MERGE once both are held.
- MERGE, 1 cycle:
  - idx < N: REGS[idx] <= (REGS[idx] & ~m) | (wdata & m), where m is the byte-expanded WSTRB.
  - idx < N and (WSTRB & TRIGGER_MASK[idx]) != 0: go to FWD.
  - Otherwise go to RESP, with OKAY for in-range indices and SLVERR (2'b10) for idx ≥ N. An out-of-range write leaves REGS untouched.
- FWD:
  - M_AXI_AWVALID and M_AXI_WVALID are held until each handshakes, independently. Both are registered, never combinational from the S side.
  - AWADDR = idx<<2, WDATA = the post-merge REGS[idx], WSTRB = 4'hF.
  - Go to WAIT_B after both have handshaken.
- WAIT_B: M_AXI_BREADY = 1. On M_AXI_BVALID, capture BRESP and go to RESP.
- RESP: S_AXIL_BVALID = 1 with the captured or local BRESP. Go to IDLE on BREADY.
- The shadow is updated in MERGE regardless of the downstream BRESP. A downstream error is reported in BRESP only.
- Reads, READ_SHADOW = 0: all AR and R signals are combinational passthrough; the upper 32-bit address is passed unmodified.
- Reads, READ_SHADOW = 1:
  - ARREADY is high when no R beat is pending. RDATA is registered from REGS[idx] at the AR handshake, and RVALID is asserted the next cycle, held until RREADY.
  - idx ≥ N returns RDATA 0 with SLVERR.
  - M_AXI_ARVALID and M_AXI_RREADY are tied to 0.

## Timing
- Reset (async assert, sync deassert in the system) drives:
  - every S and M output VALID and READY to 0;
  - every data, address and resp output to 0;
  - REGS to 0;
  - the FSM to IDLE.
- Local write: AW and W handshake in cycle 0; MERGE in cycle 1; BVALID in cycle 2.
- Forwarded write: M AWVALID and WVALID in cycle 2 at the earliest. S BVALID asserts the cycle after the M_AXI_B handshake.
- A shadow read of a register being merged returns the pre-merge value if AR handshakes in the MERGE cycle, otherwise the post-merge value.
- Reset mid-FWD or mid-WAIT_B abandons the downstream transaction. The downstream slave shares the reset.
- Back-to-back writes: AWREADY/WREADY stay low from MERGE until the cycle after the S_AXIL_B handshake.

## Structure
- Package shadow_bridge_pkg holds:
  - the wr_state_t enum (IDLE, MERGE, FWD, WAIT_B, RESP);
  - the RESP_OKAY and RESP_SLVERR constants;
  - the function strobe_expand(logic [3:0]) -> logic [31:0].
- Single module, no sub-modules. The read path is a generate-if on READ_SHADOW.

## Test plan
- Write 0x11223344, WSTRB 4'b1110, to reg 2 (mask 4'b0001) -> no M_AXI activity, BRESP OKAY; a shadow read of reg 2 returns 0x11223300.
- Then write 0x000000AB, WSTRB 4'b0001, to reg 2 -> one M write with AWADDR 0x8, WDATA 0x112233AB, WSTRB 4'hF; downstream BRESP 2'b10 is propagated to S_AXIL_BRESP.
- W arrives 3 cycles before AW; then M_AXI_AWREADY is held low for 4 cycles while WREADY=1 -> exactly one AW and one W handshake, and S BVALID is asserted only after M_AXI_B.
- Write and read to index N (addr 0x20 with N=8) -> SLVERR on both, REGS unchanged, no M traffic.
- READ_SHADOW=0: AR to 0x4 -> M_AXI_ARADDR 0x4 in the same cycle; RDATA and RRESP mirror downstream.
- Assert i_reset_n low during WAIT_B -> all VALIDs are 0 immediately, REGS reads 0 after release, and the next write completes normally.

Source files
------------

// File: rtl/shadow_bridge_pkg.sv
// Shared types and helpers for the AXI-Lite shadow register bridge.
package shadow_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      MERGE  = 3'd1,
      FWD    = 3'd2,
      WAIT_B = 3'd3,
      RESP   = 3'd4
   } wr_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic [31:0] strobe_expand(input logic [3:0] strb);
      logic [31:0] mask_v;
      mask_v = 32'h0000_0000;
      for (int b = 0; b < 4; b++) begin
         mask_v[8*b +: 8] = {8{strb[b]}};
      end
      return mask_v;
   endfunction

endpackage

// File: rtl/axil_shadow_bridge.sv
// AXI-Lite shadow bridge: merges sub-word writes into a local register copy and
// forwards full-word writes downstream only when a trigger byte lane is touched.
module axil_shadow_bridge
   import shadow_bridge_pkg::*;
#(
   parameter int           N            = 8,
   parameter logic [4*N-1:0] TRIGGER_MASK = {N{4'b0001}},
   parameter bit           READ_SHADOW  = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        S_AXIL_AWVALID,
   output logic        S_AXIL_AWREADY,
   input  logic [31:0] S_AXIL_AWADDR,
   input  logic        S_AXIL_WVALID,
   output logic        S_AXIL_WREADY,
   input  logic [31:0] S_AXIL_WDATA,
   input  logic [3:0]  S_AXIL_WSTRB,
   output logic        S_AXIL_BVALID,
   input  logic        S_AXIL_BREADY,
   output logic [1:0]  S_AXIL_BRESP,
   input  logic        S_AXIL_ARVALID,
   output logic        S_AXIL_ARREADY,
   input  logic [31:0] S_AXIL_ARADDR,
   output logic        S_AXIL_RVALID,
   input  logic        S_AXIL_RREADY,
   output logic [31:0] S_AXIL_RDATA,
   output logic [1:0]  S_AXIL_RRESP,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_AWADDR,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   input  logic [1:0]  M_AXI_BRESP,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   output logic [31:0] M_AXI_ARADDR,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP
);

   localparam int          IDXW = (N > 1) ? $clog2(N) : 1;
   localparam logic [31:0] N_L  = 32'(N);

   // Index must be below N and every address bit above the index field zero.
   function automatic logic addr_in_range(input logic [31:0] addr);
      return ((addr >> (IDXW + 2)) == 32'd0) && (32'(addr[IDXW+1:2]) < N_L);
   endfunction

   wr_state_t         state_r, state_s;
   logic [31:0]       regs_r [N];
   logic              aw_held_r, w_held_r, awready_r, wready_r;
   logic [31:0]       awaddr_r, wdata_r;
   logic [3:0]        wstrb_r;
   logic              m_awvalid_r, m_wvalid_r, m_bready_r, s_bvalid_r;
   logic [31:0]       m_awaddr_r, m_wdata_r;
   logic [1:0]        s_bresp_r;
   logic              aw_hs_s, w_hs_s, m_b_hs_s, s_b_hs_s;
   logic [IDXW-1:0]   wr_idx_s;
   logic              wr_in_range_s, wr_trig_s;
   logic [31:0]       wmask_s, merged_s;
   logic              wr_unused_s;

   assign aw_hs_s       = S_AXIL_AWVALID & awready_r;
   assign w_hs_s        = S_AXIL_WVALID & wready_r;
   assign m_b_hs_s      = M_AXI_BVALID & m_bready_r;
   assign s_b_hs_s      = s_bvalid_r & S_AXIL_BREADY;
   assign wr_idx_s      = awaddr_r[IDXW+1:2];
   assign wr_in_range_s = addr_in_range(awaddr_r);
   assign wr_trig_s     = wr_in_range_s &&
                          ((wstrb_r & TRIGGER_MASK[{wr_idx_s, 2'b00} +: 4]) != 4'b0000);
   assign wmask_s       = strobe_expand(wstrb_r);
   assign merged_s      = (regs_r[wr_idx_s] & ~wmask_s) | (wdata_r & wmask_s);
   assign wr_unused_s   = ^awaddr_r[1:0];

   // Write FSM state register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_r <= IDLE;
      else            state_r <= state_s;
   end

   // Write FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:   if ((aw_held_r | aw_hs_s) && (w_held_r | w_hs_s)) state_s = MERGE;
                 else state_s = IDLE;
         MERGE:  if (wr_trig_s) state_s = FWD;
                 else state_s = RESP;
         FWD:    if ((!m_awvalid_r || M_AXI_AWREADY) && (!m_wvalid_r || M_AXI_WREADY)) state_s = WAIT_B;
                 else state_s = FWD;
         WAIT_B: if (m_b_hs_s) state_s = RESP;
                 else state_s = WAIT_B;
         RESP:   if (s_b_hs_s) state_s = IDLE;
                 else state_s = RESP;
         default: state_s = IDLE;
      endcase
   end

   // Write datapath: capture, shadow merge, downstream channels and S-side response.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < N; i++) regs_r[i] <= 32'd0;
         aw_held_r   <= 1'b0;
         w_held_r    <= 1'b0;
         awready_r   <= 1'b0;
         wready_r    <= 1'b0;
         awaddr_r    <= 32'd0;
         wdata_r     <= 32'd0;
         wstrb_r     <= 4'd0;
         m_awvalid_r <= 1'b0;
         m_wvalid_r  <= 1'b0;
         m_bready_r  <= 1'b0;
         m_awaddr_r  <= 32'd0;
         m_wdata_r   <= 32'd0;
         s_bvalid_r  <= 1'b0;
         s_bresp_r   <= 2'b00;
      end else begin
         awready_r <= (state_s == IDLE) && !(aw_held_r || aw_hs_s);
         wready_r  <= (state_s == IDLE) && !(w_held_r || w_hs_s);
         if (aw_hs_s) begin
            aw_held_r <= 1'b1;
            awaddr_r  <= S_AXIL_AWADDR;
         end
         if (w_hs_s) begin
            w_held_r <= 1'b1;
            wdata_r  <= S_AXIL_WDATA;
            wstrb_r  <= S_AXIL_WSTRB;
         end
         case (state_r)
            MERGE: begin
               aw_held_r <= 1'b0;
               w_held_r  <= 1'b0;
               if (wr_in_range_s) regs_r[wr_idx_s] <= merged_s;
               s_bresp_r <= wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
               if (wr_trig_s) begin
                  m_awvalid_r <= 1'b1;
                  m_wvalid_r  <= 1'b1;
                  m_awaddr_r  <= 32'(wr_idx_s) << 2;
                  m_wdata_r   <= merged_s;
               end else begin
                  s_bvalid_r <= 1'b1;
               end
            end
            FWD: begin
               if (M_AXI_AWREADY) m_awvalid_r <= 1'b0;
               if (M_AXI_WREADY)  m_wvalid_r  <= 1'b0;
               if (state_s == WAIT_B) m_bready_r <= 1'b1;
            end
            WAIT_B: begin
               if (m_b_hs_s) begin
                  m_bready_r <= 1'b0;
                  s_bresp_r  <= M_AXI_BRESP;
                  s_bvalid_r <= 1'b1;
               end
            end
            RESP: begin
               if (s_b_hs_s) s_bvalid_r <= 1'b0;
            end
            default: begin
               s_bvalid_r <= s_bvalid_r;
            end
         endcase
      end
   end

   assign S_AXIL_AWREADY = awready_r;
   assign S_AXIL_WREADY  = wready_r;
   assign S_AXIL_BVALID  = s_bvalid_r;
   assign S_AXIL_BRESP   = s_bresp_r;
   assign M_AXI_AWVALID  = m_awvalid_r;
   assign M_AXI_AWADDR   = m_awaddr_r;
   assign M_AXI_WVALID   = m_wvalid_r;
   assign M_AXI_WDATA    = m_wdata_r;
   assign M_AXI_WSTRB    = 4'hF;
   assign M_AXI_BREADY   = m_bready_r;

   generate
      if (READ_SHADOW) begin : g_rd_shadow
         logic        arready_r, rvalid_r;
         logic [31:0] rdata_r;
         logic [1:0]  rresp_r;
         logic        ar_hs_s, r_hs_s, rd_ok_s;
         logic        rd_unused_s;

         assign ar_hs_s     = S_AXIL_ARVALID & arready_r;
         assign r_hs_s      = rvalid_r & S_AXIL_RREADY;
         assign rd_ok_s     = addr_in_range(S_AXIL_ARADDR);
         assign rd_unused_s = ^{M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
                                S_AXIL_ARADDR[1:0]};

         // One-deep read response register served from the shadow copy.
         always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
               arready_r <= 1'b0;
               rvalid_r  <= 1'b0;
               rdata_r   <= 32'd0;
               rresp_r   <= 2'b00;
            end else if (ar_hs_s) begin
               arready_r <= 1'b0;
               rvalid_r  <= 1'b1;
               rdata_r   <= rd_ok_s ? regs_r[S_AXIL_ARADDR[IDXW+1:2]] : 32'd0;
               rresp_r   <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else if (r_hs_s) begin
               arready_r <= 1'b1;
               rvalid_r  <= 1'b0;
            end else begin
               arready_r <= !rvalid_r;
            end
         end

         assign S_AXIL_ARREADY = arready_r;
         assign S_AXIL_RVALID  = rvalid_r;
         assign S_AXIL_RDATA   = rdata_r;
         assign S_AXIL_RRESP   = rresp_r;
         assign M_AXI_ARVALID  = 1'b0;
         assign M_AXI_ARADDR   = 32'd0;
         assign M_AXI_RREADY   = 1'b0;
      end else begin : g_rd_pass
         assign M_AXI_ARVALID  = S_AXIL_ARVALID;
         assign M_AXI_ARADDR   = S_AXIL_ARADDR;
         assign S_AXIL_ARREADY = M_AXI_ARREADY;
         assign S_AXIL_RVALID  = M_AXI_RVALID;
         assign S_AXIL_RDATA   = M_AXI_RDATA;
         assign S_AXIL_RRESP   = M_AXI_RRESP;
         assign M_AXI_RREADY   = S_AXIL_RREADY;
      end
   endgenerate

endmodule

// File: tb/tb_axil_shadow_bridge.sv
// Directed bench: shadow-read instance plus a passthrough-read instance, with a small downstream slave.
module tb_axil_shadow_bridge;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Shadow-read instance signals
   logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;
   logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] s_rdata;
   logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
   logic [31:0] m_awaddr, m_wdata, m_araddr;
   logic [3:0]  m_wstrb;
   logic        m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
   logic [1:0]  m_bresp, m_rresp;
   logic [31:0] m_rdata;

   // Passthrough-read instance signals
   logic        pt_arvalid, pt_rready, pt_m_arready, pt_m_rvalid;
   logic [31:0] pt_araddr, pt_m_rdata;
   logic [1:0]  pt_m_rresp;
   logic        pt_s_arready, pt_s_rvalid, pt_m_arvalid, pt_m_rready;
   logic [31:0] pt_s_rdata, pt_m_araddr;
   logic [1:0]  pt_s_rresp;
   logic        pt_awready, pt_wready, pt_bvalid, pt_m_awvalid, pt_m_wvalid, pt_m_bready;
   logic [1:0]  pt_bresp;
   logic [31:0] pt_m_awaddr, pt_m_wdata;
   logic [3:0]  pt_m_wstrb;
   logic        zero1 = 1'b0;
   logic [1:0]  zero2 = 2'b00;
   logic [3:0]  zero4 = 4'b0000;
   logic [31:0] zero32 = 32'd0;

   // Downstream slave model state
   logic        got_aw, got_w, b_hold;
   int          aw_cnt = 0;
   int          w_cnt = 0;
   logic [31:0] last_awaddr, last_wdata;
   logic [3:0]  last_wstrb;

   axil_shadow_bridge #(.N(8), .TRIGGER_MASK({8{4'b0001}}), .READ_SHADOW(1'b1)) dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .S_AXIL_AWVALID(s_awvalid), .S_AXIL_AWREADY(s_awready), .S_AXIL_AWADDR(s_awaddr),
      .S_AXIL_WVALID(s_wvalid), .S_AXIL_WREADY(s_wready), .S_AXIL_WDATA(s_wdata), .S_AXIL_WSTRB(s_wstrb),
      .S_AXIL_BVALID(s_bvalid), .S_AXIL_BREADY(s_bready), .S_AXIL_BRESP(s_bresp),
      .S_AXIL_ARVALID(s_arvalid), .S_AXIL_ARREADY(s_arready), .S_AXIL_ARADDR(s_araddr),
      .S_AXIL_RVALID(s_rvalid), .S_AXIL_RREADY(s_rready), .S_AXIL_RDATA(s_rdata), .S_AXIL_RRESP(s_rresp),
      .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready), .M_AXI_AWADDR(m_awaddr),
      .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
      .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready), .M_AXI_BRESP(m_bresp),
      .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready), .M_AXI_ARADDR(m_araddr),
      .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready), .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp)
   );

   axil_shadow_bridge #(.N(8), .TRIGGER_MASK({8{4'b0001}}), .READ_SHADOW(1'b0)) dut_pt (
      .i_clk(clk), .i_reset_n(rst_n),
      .S_AXIL_AWVALID(zero1), .S_AXIL_AWREADY(pt_awready), .S_AXIL_AWADDR(zero32),
      .S_AXIL_WVALID(zero1), .S_AXIL_WREADY(pt_wready), .S_AXIL_WDATA(zero32), .S_AXIL_WSTRB(zero4),
      .S_AXIL_BVALID(pt_bvalid), .S_AXIL_BREADY(zero1), .S_AXIL_BRESP(pt_bresp),
      .S_AXIL_ARVALID(pt_arvalid), .S_AXIL_ARREADY(pt_s_arready), .S_AXIL_ARADDR(pt_araddr),
      .S_AXIL_RVALID(pt_s_rvalid), .S_AXIL_RREADY(pt_rready), .S_AXIL_RDATA(pt_s_rdata), .S_AXIL_RRESP(pt_s_rresp),
      .M_AXI_AWVALID(pt_m_awvalid), .M_AXI_AWREADY(zero1), .M_AXI_AWADDR(pt_m_awaddr),
      .M_AXI_WVALID(pt_m_wvalid), .M_AXI_WREADY(zero1), .M_AXI_WDATA(pt_m_wdata), .M_AXI_WSTRB(pt_m_wstrb),
      .M_AXI_BVALID(zero1), .M_AXI_BREADY(pt_m_bready), .M_AXI_BRESP(zero2),
      .M_AXI_ARVALID(pt_m_arvalid), .M_AXI_ARREADY(pt_m_arready), .M_AXI_ARADDR(pt_m_araddr),
      .M_AXI_RVALID(pt_m_rvalid), .M_AXI_RREADY(pt_m_rready), .M_AXI_RDATA(pt_m_rdata), .M_AXI_RRESP(pt_m_rresp)
   );

   // Downstream write slave: accepts AW/W independently, answers B once both arrived.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         got_aw   <= 1'b0;
         got_w    <= 1'b0;
         m_bvalid <= 1'b0;
      end else begin
         if (m_awvalid && m_awready) begin
            got_aw      <= 1'b1;
            aw_cnt      <= aw_cnt + 1;
            last_awaddr <= m_awaddr;
         end
         if (m_wvalid && m_wready) begin
            got_w      <= 1'b1;
            w_cnt      <= w_cnt + 1;
            last_wdata <= m_wdata;
            last_wstrb <= m_wstrb;
         end
         if (got_aw && got_w && !m_bvalid && !b_hold) begin
            m_bvalid <= 1'b1;
            got_aw   <= 1'b0;
            got_w    <= 1'b0;
         end
         if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic s_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic do_aw, input logic do_w);
      logic aw_go, w_go;
      s_awaddr = addr;
      s_wdata  = data;
      s_wstrb  = strb;
      s_awvalid = do_aw;
      s_wvalid  = do_w;
      for (int i = 0; i < 20 && (s_awvalid || s_wvalid); i++) begin
         aw_go = s_awvalid && s_awready;
         w_go  = s_wvalid && s_wready;
         step();
         if (aw_go) s_awvalid = 1'b0;
         if (w_go)  s_wvalid  = 1'b0;
      end
      chk("s_write_handshake_timeout", {30'd0, s_awvalid, s_wvalid}, 32'd0);
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
   endtask

   task automatic wait_bresp(input string tag, input logic [1:0] exp_resp, input logic fwd);
      logic mb_seen;
      mb_seen = 1'b0;
      for (int i = 0; i < 50 && !s_bvalid; i++) begin
         if (m_bvalid && m_bready) mb_seen = 1'b1;
         step();
      end
      chk({tag, "_bvalid"}, {31'd0, s_bvalid}, 32'd1);
      chk({tag, "_bresp"}, {30'd0, s_bresp}, {30'd0, exp_resp});
      if (fwd) chk({tag, "_b_after_mb"}, {31'd0, mb_seen}, 32'd1);
      s_bready = 1'b1;
      step();
      s_bready = 1'b0;
      chk({tag, "_ready_after_b"}, {29'd0, s_bvalid, s_awready, s_wready}, 32'd3);
   endtask

   task automatic s_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      s_araddr  = addr;
      s_arvalid = 1'b1;
      for (int i = 0; i < 20 && !s_arready; i++) step();
      step();
      s_arvalid = 1'b0;
      for (int i = 0; i < 20 && !s_rvalid; i++) step();
      chk("rd_rvalid", {31'd0, s_rvalid}, 32'd1);
      data = s_rdata;
      resp = s_rresp;
      s_rready = 1'b1;
      step();
      s_rready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [1:0]  rr;
      int          aw0, w0;
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
      s_awaddr = 32'd0; s_wdata = 32'd0; s_wstrb = 4'd0; s_araddr = 32'd0;
      m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'b00; b_hold = 1'b0;
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0; m_rresp = 2'b00;
      pt_arvalid = 1'b0; pt_rready = 1'b0; pt_araddr = 32'd0;
      pt_m_arready = 1'b0; pt_m_rvalid = 1'b0; pt_m_rdata = 32'd0; pt_m_rresp = 2'b00;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valids_readies", {24'd0, s_awready, s_wready, s_bvalid, s_arready, s_rvalid,
                                 m_awvalid, m_wvalid, m_bready}, 32'd0);
      chk("rst_resp", {28'd0, s_bresp, s_rresp}, 32'd0);
      chk("rst_rdata", s_rdata, 32'd0);
      chk("rst_m_awaddr", m_awaddr, 32'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", {30'd0, s_awready, s_wready}, 32'd3);

      // Local (non-trigger) merge into reg 2
      s_write(32'h0000_0008, 32'h1122_3344, 4'b1110, 1'b1, 1'b1);
      chk("merge_awready_low", {31'd0, s_awready}, 32'd0);
      chk("merge_no_bvalid", {31'd0, s_bvalid}, 32'd0);
      step();
      chk("local_bvalid_cycle2", {31'd0, s_bvalid}, 32'd1);
      wait_bresp("local", 2'b00, 1'b0);
      chk("local_no_m_aw", aw_cnt, 32'd0);
      chk("local_no_m_w", w_cnt, 32'd0);
      s_read(32'h0000_0008, rd, rr);
      chk("rd_reg2_local", rd, 32'h1122_3300);
      chk("rd_reg2_local_resp", {30'd0, rr}, 32'd0);

      // Trigger write to reg 2 with downstream SLVERR
      m_bresp = 2'b10;
      aw0 = aw_cnt;
      s_write(32'h0000_0008, 32'h0000_00AB, 4'b0001, 1'b1, 1'b1);
      step();
      chk("fwd_awvalid_cycle2", {30'd0, m_awvalid, m_wvalid}, 32'd3);
      chk("fwd_awaddr_out", m_awaddr, 32'h0000_0008);
      wait_bresp("fwd_err", 2'b10, 1'b1);
      chk("fwd_aw_count", aw_cnt - aw0, 32'd1);
      chk("fwd_awaddr", last_awaddr, 32'h0000_0008);
      chk("fwd_wdata", last_wdata, 32'h1122_33AB);
      chk("fwd_wstrb", {28'd0, last_wstrb}, 32'h0000_000F);
      m_bresp = 2'b00;

      // W three cycles before AW, downstream AWREADY stalled
      m_awready = 1'b0;
      aw0 = aw_cnt;
      w0 = w_cnt;
      s_write(32'h0, 32'h5A5A_5A5A, 4'b0001, 1'b0, 1'b1);
      step();
      step();
      chk("w_held_ready", {30'd0, s_awready, s_wready}, 32'd2);
      s_write(32'h0000_0004, 32'h0, 4'b0000, 1'b1, 1'b0);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("stall_aw_held_no_b", {30'd0, m_awvalid, s_bvalid}, 32'd2);
         step();
      end
      chk("stall_w_once", w_cnt - w0, 32'd1);
      m_awready = 1'b1;
      wait_bresp("stall", 2'b00, 1'b1);
      chk("stall_aw_once", aw_cnt - aw0, 32'd1);
      chk("stall_w_total", w_cnt - w0, 32'd1);
      chk("stall_awaddr", last_awaddr, 32'h0000_0004);
      chk("stall_wdata", last_wdata, 32'h0000_005A);

      // Out-of-range write and read at index N
      aw0 = aw_cnt;
      s_write(32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 1'b1, 1'b1);
      wait_bresp("oor_wr", 2'b10, 1'b0);
      chk("oor_no_m_aw", aw_cnt - aw0, 32'd0);
      s_read(32'h0000_0020, rd, rr);
      chk("oor_rd_data", rd, 32'd0);
      chk("oor_rd_resp", {30'd0, rr}, 32'd2);
      s_read(32'h0000_0000, rd, rr);
      chk("oor_reg0_unchanged", rd, 32'd0);
      s_read(32'h0000_0008, rd, rr);
      chk("oor_reg2_unchanged", rd, 32'h1122_33AB);

      // Passthrough read instance
      pt_arvalid = 1'b1; pt_araddr = 32'h0000_0004; pt_rready = 1'b1;
      pt_m_arready = 1'b1; pt_m_rvalid = 1'b1; pt_m_rdata = 32'hCAFE_F00D; pt_m_rresp = 2'b01;
      #1;
      chk("pt_araddr", pt_m_araddr, 32'h0000_0004);
      chk("pt_ar_handshake", {30'd0, pt_m_arvalid, pt_s_arready}, 32'd3);
      chk("pt_rdata", pt_s_rdata, 32'hCAFE_F00D);
      chk("pt_r_ctrl", {28'd0, pt_s_rvalid, pt_m_rready, pt_s_rresp}, 32'h0000_000D);
      pt_araddr = 32'h8000_0004; pt_rready = 1'b0; pt_m_rresp = 2'b10;
      #1;
      chk("pt_araddr_upper", pt_m_araddr, 32'h8000_0004);
      chk("pt_r_ctrl2", {28'd0, pt_s_rvalid, pt_m_rready, pt_s_rresp}, 32'h0000_000A);
      pt_arvalid = 1'b0; pt_m_rvalid = 1'b0; pt_m_arready = 1'b0;
      step();

      // Reset during WAIT_B
      b_hold = 1'b1;
      s_write(32'h0000_000C, 32'h0000_0077, 4'b0001, 1'b1, 1'b1);
      for (int i = 0; i < 20 && !m_bready; i++) step();
      chk("waitb_reached", {31'd0, m_bready}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valids", {24'd0, s_bvalid, m_awvalid, m_wvalid, m_bready,
                              s_awready, s_wready, s_arready, s_rvalid}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      b_hold = 1'b0;
      step();
      s_read(32'h0000_0008, rd, rr);
      chk("rst_reg2_cleared", rd, 32'd0);
      s_read(32'h0000_000C, rd, rr);
      chk("rst_reg3_cleared", rd, 32'd0);
      aw0 = aw_cnt;
      s_write(32'h0000_0000, 32'h0000_0012, 4'b0001, 1'b1, 1'b1);
      wait_bresp("post_rst_wr", 2'b00, 1'b1);
      chk("post_rst_aw_once", aw_cnt - aw0, 32'd1);
      chk("post_rst_wdata", last_wdata, 32'h0000_0012);
      chk("post_rst_awaddr", last_awaddr, 32'h0000_0000);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
